// File: rtl/iob_round.sv
// iob_round: two-stage round-to-nearest-even of a normalized mantissa,
// with carry renormalization, inexact flag and exponent-overflow saturation.
module iob_round #(
   parameter int EXP_W  = 8,
   parameter int DATA_W = 32,
   parameter int MAN_W  = 24
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [EXP_W-1:0]  exp_i,
   input  logic [DATA_W-1:0] man_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [EXP_W-1:0]  exp_o,
   output logic [MAN_W-1:0]  man_o,
   output logic             inexact_o,
   output logic             ovf_o
);

   localparam int LOW_W = DATA_W - MAN_W - 1;
   localparam logic [EXP_W-1:0] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};
   localparam logic [MAN_W-1:0] MAN_ONE = {1'b1, {(MAN_W-1){1'b0}}};

   logic             v1;
   logic             v2;
   logic             adv1;
   logic             adv2;
   logic             take1;
   logic             take2;

   logic [MAN_W-1:0] kept1;
   logic [EXP_W-1:0] exp1;
   logic             inc1;
   logic             inx1;
   logic             zero1;

   logic [MAN_W-1:0] kept_n;
   logic             g_n;
   logic             s_n;

   logic [MAN_W:0]   sum;
   logic [MAN_W-1:0] man_n;
   logic [EXP_W-1:0] exp_n;
   logic             inx_n;
   logic             ovf_n;

   // A stage may advance when it is empty or its contents move on
   assign adv2    = ~v2 | ready_i;
   assign adv1    = ~v1 | adv2;
   assign ready_o = adv1;
   assign take1   = valid_i & adv1;
   assign take2   = v1 & adv2;
   assign valid_o = v2;

   assign kept_n = man_i[DATA_W-1 -: MAN_W];
   assign g_n    = man_i[LOW_W];
   assign s_n    = |man_i[LOW_W-1:0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1    <= 1'b0;
         kept1 <= '0;
         exp1  <= '0;
         inc1  <= 1'b0;
         inx1  <= 1'b0;
         zero1 <= 1'b0;
      end else begin
         if (adv1) v1 <= valid_i;
         if (take1) begin
            kept1 <= kept_n;
            exp1  <= exp_i;
            inc1  <= g_n & (s_n | kept_n[0]);
            inx1  <= g_n | s_n;
            zero1 <= (man_i == '0);
         end
      end
   end

   assign sum = {1'b0, kept1} + {{MAN_W{1'b0}}, inc1};

   always_comb begin
      man_n = sum[MAN_W-1:0];
      exp_n = exp1;
      inx_n = inx1;
      ovf_n = 1'b0;
      if (zero1) begin
         man_n = '0;
         exp_n = '0;
         inx_n = 1'b0;
      end else if (sum[MAN_W]) begin
         // Carry-out: renormalize, or saturate at the largest exponent
         if (exp1 == EXP_MAX) begin
            man_n = '1;
            ovf_n = 1'b1;
         end else begin
            man_n = MAN_ONE;
            exp_n = exp1 + EXP_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v2        <= 1'b0;
         exp_o     <= '0;
         man_o     <= '0;
         inexact_o <= 1'b0;
         ovf_o     <= 1'b0;
      end else begin
         if (adv2) v2 <= v1;
         if (take2) begin
            exp_o     <= exp_n;
            man_o     <= man_n;
            inexact_o <= inx_n;
            ovf_o     <= ovf_n;
         end
      end
   end

endmodule

// File: tb/tb_iob_round.sv
// tb_iob_round: directed vector table plus handshake, backpressure
// and mid-flight reset sequences for iob_round.
module tb_iob_round;

   logic        clk_i;
   logic        rst_n_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  exp_i;
   logic [31:0] man_i;
   logic        valid_o;
   logic        ready_i;
   logic [7:0]  exp_o;
   logic [23:0] man_o;
   logic        inexact_o;
   logic        ovf_o;

   iob_round #(.EXP_W(8), .DATA_W(32), .MAN_W(24)) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .exp_i     (exp_i),
      .man_i     (man_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .exp_o     (exp_o),
      .man_o     (man_o),
      .inexact_o (inexact_o),
      .ovf_o     (ovf_o)
   );

   typedef struct {
      logic [7:0]  e;
      logic [31:0] m;
      logic [7:0]  xe;
      logic [23:0] xm;
      logic        xi;
      logic        xo;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   logic [33:0] sb [$];
   int tests;
   int fails;
   int outs;
   int ins;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] e, input logic [31:0] m,
                               input logic [7:0] xe, input logic [23:0] xm,
                               input logic xi, input logic xo);
      vec_t v;
      v.e = e; v.m = m; v.xe = xe; v.xm = xm; v.xi = xi; v.xo = xo;
      return v;
   endfunction

   function automatic logic [33:0] expv(input vec_t v);
      return {v.xe, v.xm, v.xi, v.xo};
   endfunction

   // Output monitor: every transfer out must match the oldest accepted input
   always @(negedge clk_i) begin
      if (rst_n_i && valid_o && ready_i) begin
         outs++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %h expected none",
                     {exp_o, man_o, inexact_o, ovf_o});
         end else begin
            check("out_data", 64'({exp_o, man_o, inexact_o, ovf_o}),
                  64'(sb.pop_front()));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input vec_t v);
      int n;
      valid_i = 1'b1;
      exp_i   = v.e;
      man_i   = v.m;
      n = 0;
      @(negedge clk_i);
      while (!ready_o && n < 100) begin
         n++;
         @(negedge clk_i);
      end
      if (!ready_o) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got ready_o=0 expected 1");
      end else begin
         sb.push_back(expv(v));
         ins++;
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         n++;
         @(negedge clk_i);
      end
      check("drain", 64'(sb.size()), 64'd0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      tests = 0; fails = 0; outs = 0; ins = 0;
      tbl[0]  = mk(8'h05, 32'h80000080, 8'h05, 24'h800000, 1, 0);
      tbl[1]  = mk(8'h05, 32'h80000180, 8'h05, 24'h800002, 1, 0);
      tbl[2]  = mk(8'h05, 32'h800001C0, 8'h05, 24'h800002, 1, 0);
      tbl[3]  = mk(8'h05, 32'h80000140, 8'h05, 24'h800001, 1, 0);
      tbl[4]  = mk(8'h05, 32'hFFFFFF80, 8'h06, 24'h800000, 1, 0);
      tbl[5]  = mk(8'h05, 32'hC0000000, 8'h05, 24'hC00000, 0, 0);
      tbl[6]  = mk(8'h12, 32'h00000000, 8'h00, 24'h000000, 0, 0);
      tbl[7]  = mk(8'h7F, 32'hFFFFFFFF, 8'h7F, 24'hFFFFFF, 1, 1);
      tbl[8]  = mk(8'hFF, 32'hFFFFFF80, 8'h00, 24'h800000, 1, 0);
      tbl[9]  = mk(8'h7F, 32'h80000000, 8'h7F, 24'h800000, 0, 0);
      tbl[10] = mk(8'h81, 32'hFFFFFFC0, 8'h82, 24'h800000, 1, 0);
      tbl[11] = mk(8'h7E, 32'hFFFFFF80, 8'h7F, 24'h800000, 1, 0);
      tbl[12] = mk(8'h03, 32'h80000001, 8'h03, 24'h800000, 1, 0);
      tbl[13] = mk(8'h03, 32'h800000FF, 8'h03, 24'h800001, 1, 0);
      tbl[14] = mk(8'h03, 32'h00000080, 8'h03, 24'h000000, 1, 0);

      rst_n_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      exp_i   = '0;
      man_i   = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_outputs", 64'({valid_o, exp_o, man_o, inexact_o, ovf_o}),
            64'd0);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Latency: one transaction into an empty pipe
      send(tbl[0]);
      @(negedge clk_i);
      check("latency_c1", 64'(valid_o), 64'd0);
      @(negedge clk_i);
      check("latency_c2", 64'(valid_o), 64'd1);
      @(posedge clk_i);
      #1;
      drain();

      // Table back-to-back at full throughput
      for (int i = 0; i < NV; i++) send(tbl[i]);
      drain();

      // Table again with ready_i toggling every cycle
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               @(posedge clk_i);
               #1;
               ready_i = ~ready_i;
            end
            ready_i = 1'b1;
         end
         begin
            for (int i = 0; i < NV; i++) send(tbl[NV-1-i]);
         end
      join
      drain();

      // Backpressure: empty pipe with ready_i low absorbs exactly two
      ready_i = 1'b0;
      send(tbl[4]);
      send(tbl[7]);
      valid_i = 1'b1;
      exp_i   = tbl[0].e;
      man_i   = tbl[0].m;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("bp_ready_low", 64'(ready_o), 64'd0);
         check("bp_hold", 64'({valid_o, exp_o, man_o, inexact_o, ovf_o}),
               64'({1'b1, expv(tbl[4])}));
      end
      @(posedge clk_i);
      #1;
      ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_ready_rise", 64'(ready_o), 64'd1);
      sb.push_back(expv(tbl[0]));
      ins++;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      drain();
      check("in_out_count", 64'(outs), 64'(ins));

      // Reset with two transactions in flight
      ready_i = 1'b0;
      send(tbl[1]);
      send(tbl[2]);
      #2;
      rst_n_i = 1'b0;
      #1;
      check("async_reset", 64'({valid_o, exp_o, man_o, inexact_o, ovf_o}),
            64'd0);
      sb.delete();
      ins = outs;
      ready_i = 1'b1;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("post_reset_idle", 64'(valid_o), 64'd0);
      end
      check("post_reset_count", 64'(outs), 64'(ins));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
